// File: rtl/cache_pkg.sv
// Shared definitions for the cache/memory arbiter: block geometry,
// FSM state encoding and transfer-owner encoding.
package cache_pkg;

    localparam int OFST = 5;
    localparam int BLCK = 8 << OFST;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I$ / D$ request ports and the shared memory port.
// slave  = arbiter side, master = requesters plus memory model.
interface cache_mem_arbiter_if
    import cache_pkg::*;
#(
    parameter int ADDR = 32,
    parameter int BLCK = cache_pkg::BLCK
);

    logic            i_req;
    logic [ADDR-1:0] i_addr;
    logic            i_done;
    logic [BLCK-1:0] i_block;

    logic            d_req;
    logic            d_we;
    logic [ADDR-1:0] d_addr;
    logic [BLCK-1:0] d_wblock;
    logic            d_done;
    logic [BLCK-1:0] d_rblock;

    logic            m_req;
    logic            m_we;
    logic [ADDR-1:0] m_addr;
    logic [BLCK-1:0] m_wdata;
    logic [BLCK-1:0] m_rdata;
    logic            m_ack;

    logic            err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wblock, m_rdata, m_ack,
        output i_done, i_block, d_done, d_rblock, m_req, m_we, m_addr, m_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wblock, m_rdata, m_ack,
        input  i_done, i_block, d_done, d_rblock, m_req, m_we, m_addr, m_wdata, err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Bit 0 = I$, bit 1 = D$; on a tie the
// requester that did not win last time is granted.
module rr_arb2
    import cache_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant: sole requester wins, a tie goes to the one not equal to last
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == OWN_I) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single main-memory port between I$ refills and D$
// refill/writeback transfers, one outstanding transfer at a time,
// with a watchdog that ends transfers the memory never acknowledges.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR = 32,
    parameter int OFST = cache_pkg::OFST,
    parameter int TMO  = 64
) (
    input  logic                CLK,
    input  logic                RESET,
    cache_mem_arbiter_if.slave  bus
);

    localparam int BW = 8 << OFST;
    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TMO - 1);
    localparam logic [ADDR-1:0] MASK     = {{(ADDR-OFST){1'b0}}, {OFST{1'b1}}};

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            last_q,  last_d;
    logic            own_q,   own_d;
    logic            we_q,    we_d;
    logic            err_q,   err_d;
    logic [ADDR-1:0] addr_q,  addr_d;
    logic [BW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   rdata_q, rdata_d;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            busy;
    logic            done;

    assign req = {bus.d_req, bus.i_req};

    rr_arb2 u_arb (
        .req   (req),
        .last  (last_q),
        .grant (gnt)
    );

    // Next-state logic: grant in IDLE, count/ack/timeout in BUSY, one-cycle DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        own_d   = own_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    own_d   = gnt[1];
                    last_d  = gnt[1];
                    we_d    = gnt[1] & bus.d_we;
                    addr_d  = (gnt[1] ? bus.d_addr : bus.i_addr) & ~MASK;
                    wdata_d = gnt[1] ? bus.d_wblock : '0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // An ack on the timeout cycle still counts as a normal completion
                if (bus.m_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = bus.m_rdata;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and the captured read block, cleared by reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= OWN_I;
            own_q   <= OWN_I;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            own_q   <= own_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Latched transfer address and write data; only visible while BUSY
    always_ff @(posedge CLK) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);

    assign bus.m_req    = busy;
    assign bus.m_we     = busy & we_q;
    assign bus.m_addr   = busy ? addr_q  : '0;
    assign bus.m_wdata  = busy ? wdata_q : '0;

    assign bus.i_done   = done & (own_q == OWN_I);
    assign bus.d_done   = done & (own_q == OWN_D);
    assign bus.err      = done & err_q;
    assign bus.i_block  = rdata_q;
    assign bus.d_rblock = rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter (TMO reduced to 8).
module tb_cache_mem_arbiter;

    localparam int TMO = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cache_mem_arbiter_if #(.ADDR(32), .BLCK(256)) bus ();

    cache_mem_arbiter #(.ADDR(32), .OFST(5), .TMO(TMO)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [255:0] a5;
        logic [255:0] wb;
        total = 0;
        bad   = 0;
        a5 = {32{8'hA5}};
        wb = {8{32'h12345678}};

        rst_n        = 1'b0;
        bus.i_req    = 1'b0;
        bus.i_addr   = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wblock = '0;
        bus.m_rdata  = '0;
        bus.m_ack    = 1'b0;
        tick();
        tick();

        // reset state
        chk1("rst_m_req", bus.m_req, 1'b0);
        chk1("rst_i_done", bus.i_done, 1'b0);
        chk1("rst_d_done", bus.d_done, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chkv("rst_block", bus.i_block, 256'd0);
        chkv("rst_m_addr", 256'(bus.m_addr), 256'd0);
        rst_n = 1'b1;
        tick();

        // 1: I$ refill alone, ack in the 4th BUSY cycle
        bus.i_addr = 32'h0000_1234;
        bus.i_req  = 1'b1;
        tick();
        chk1("t1_m_req", bus.m_req, 1'b1);
        chkv("t1_m_addr", 256'(bus.m_addr), 256'h1220);
        chk1("t1_m_we", bus.m_we, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("t1_hold_req", bus.m_req, 1'b1);
            chkv("t1_hold_addr", 256'(bus.m_addr), 256'h1220);
            chk1("t1_no_done", bus.i_done, 1'b0);
        end
        bus.m_ack   = 1'b1;
        bus.m_rdata = a5;
        tick();
        bus.m_ack = 1'b0;
        bus.i_req = 1'b0;
        chk1("t1_i_done", bus.i_done, 1'b1);
        chk1("t1_d_done", bus.d_done, 1'b0);
        chk1("t1_err", bus.err, 1'b0);
        chk1("t1_m_req_off", bus.m_req, 1'b0);
        chkv("t1_i_block", bus.i_block, a5);
        tick();
        chk1("t1_done_pulse", bus.i_done, 1'b0);

        // 2: D$ writeback, ack after 2 cycles
        bus.d_we     = 1'b1;
        bus.d_addr   = 32'h8000_0040;
        bus.d_wblock = wb;
        bus.d_req    = 1'b1;
        tick();
        chk1("t2_m_we", bus.m_we, 1'b1);
        chkv("t2_m_addr", 256'(bus.m_addr), 256'h8000_0040);
        chkv("t2_m_wdata", bus.m_wdata, wb);
        tick();
        bus.m_ack = 1'b1;
        tick();
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        chk1("t2_d_done", bus.d_done, 1'b1);
        chk1("t2_i_done", bus.i_done, 1'b0);
        chk1("t2_err", bus.err, 1'b0);
        chkv("t2_block_kept", bus.d_rblock, a5);
        tick();
        chk1("t2_done_pulse", bus.d_done, 1'b0);

        // 3: contention from reset, ack held high: D,I,D,I
        rst_n = 1'b0;
        tick();
        rst_n       = 1'b1;
        bus.i_addr  = 32'h0000_0100;
        bus.d_addr  = 32'h0000_0200;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        bus.m_ack   = 1'b1;
        bus.m_rdata = {64{4'h7}};
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk1($sformatf("t3_d_done_c%0d", k), bus.d_done, (k == 2 || k == 8));
            chk1($sformatf("t3_i_done_c%0d", k), bus.i_done, (k == 5 || k == 11));
            if (k == 1 || k == 7)  chkv($sformatf("t3_addr_c%0d", k), 256'(bus.m_addr), 256'h200);
            if (k == 4 || k == 10) chkv($sformatf("t3_addr_c%0d", k), 256'(bus.m_addr), 256'h100);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.m_ack = 1'b0;
        tick();
        chk1("t3_idle", bus.m_req, 1'b0);

        // 4: timeout, then a normal transfer
        bus.d_addr = 32'h0000_0040;
        bus.d_req  = 1'b1;
        tick();
        chk1("t4_busy1", bus.m_req, 1'b1);
        for (int k = 2; k <= TMO; k++) begin
            tick();
            chk1($sformatf("t4_busy%0d", k), bus.m_req, 1'b1);
            chk1($sformatf("t4_nodone%0d", k), bus.d_done, 1'b0);
        end
        tick();
        bus.d_req = 1'b0;
        chk1("t4_d_done", bus.d_done, 1'b1);
        chk1("t4_err", bus.err, 1'b1);
        chk1("t4_m_req_off", bus.m_req, 1'b0);
        tick();
        chk1("t4_err_pulse", bus.err, 1'b0);
        bus.i_addr = 32'h0000_2000;
        bus.i_req  = 1'b1;
        tick();
        chkv("t4_next_addr", 256'(bus.m_addr), 256'h2000);
        bus.m_ack   = 1'b1;
        bus.m_rdata = {32{8'h5A}};
        tick();
        bus.m_ack = 1'b0;
        bus.i_req = 1'b0;
        chk1("t4_next_done", bus.i_done, 1'b1);
        chk1("t4_next_err", bus.err, 1'b0);
        chkv("t4_next_block", bus.i_block, {32{8'h5A}});
        tick();

        // 5: reset on BUSY cycle 2, late ack ignored, tie restarts with D
        bus.d_addr = 32'h0000_0300;
        bus.d_req  = 1'b1;
        tick();
        chk1("t5_busy1", bus.m_req, 1'b1);
        tick();
        rst_n     = 1'b0;
        bus.d_req = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("t5_m_req_drop", bus.m_req, 1'b0);
        chk1("t5_no_done", bus.d_done, 1'b0);
        bus.m_ack   = 1'b1;
        bus.m_rdata = {64{4'hF}};
        tick();
        bus.m_ack = 1'b0;
        chk1("t5_ack_ignored", bus.m_req, 1'b0);
        chk1("t5_ack_no_done", bus.d_done, 1'b0);
        chkv("t5_block_cleared", bus.i_block, 256'd0);
        bus.i_addr = 32'h0000_0FFF;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        tick();
        chkv("t5_tie_d_first", 256'(bus.m_addr), 256'h300);
        bus.m_ack   = 1'b1;
        bus.m_rdata = {32{8'h3C}};
        tick();
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        chk1("t5_d_done", bus.d_done, 1'b1);
        chk1("t5_i_done", bus.i_done, 1'b0);
        tick();

        // 6: ack on the final BUSY cycle beats the timeout
        tick();
        chkv("t6_addr", 256'(bus.m_addr), 256'h0FE0);
        for (int k = 2; k <= TMO; k++) begin
            tick();
        end
        chk1("t6_last_busy", bus.m_req, 1'b1);
        bus.m_ack   = 1'b1;
        bus.m_rdata = {32{8'hC3}};
        tick();
        bus.m_ack = 1'b0;
        bus.i_req = 1'b0;
        chk1("t6_i_done", bus.i_done, 1'b1);
        chk1("t6_err", bus.err, 1'b0);
        chkv("t6_block", bus.i_block, {32{8'hC3}});
        tick();
        chk1("t6_idle", bus.m_req, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
